// File: rtl/e203_ifu_pkg.sv
// e203_ifu_pkg: shared IFU constants and the flush/halt responder state type
package e203_ifu_pkg;
  localparam int PC_INCR = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;
  typedef enum logic {RUN, HALT} ifu_state_e;
endpackage

// File: rtl/e203_ifu_flush_rsp_if.sv
// e203_ifu_flush_rsp_if: flush/halt handshake plus fetch request/response bus (pipe_flush_pc only with E203_FLUSH_PC_DIRECT_EN)
interface e203_ifu_flush_rsp_if #(parameter int PC_W = 32);
  logic pipe_flush_req;
  logic pipe_flush_ack;
  logic [PC_W-1:0] pipe_flush_add_op1;
  logic [PC_W-1:0] pipe_flush_add_op2;
`ifdef E203_FLUSH_PC_DIRECT_EN
  logic [PC_W-1:0] pipe_flush_pc;
`endif
  logic halt_req;
  logic halt_ack;
  logic ifu_req_valid;
  logic ifu_req_ready;
  logic [PC_W-1:0] ifu_req_pc;
  logic ifu_rsp_valid;
  logic ifu_rsp_ready;
  logic rsp_keep;
  logic [PC_W-1:0] rsp_pc;
  modport slave (
    input pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
`ifdef E203_FLUSH_PC_DIRECT_EN
    input pipe_flush_pc,
`endif
    input halt_req, ifu_req_ready, ifu_rsp_valid,
    output pipe_flush_ack, halt_ack, ifu_req_valid, ifu_req_pc, ifu_rsp_ready, rsp_keep, rsp_pc
  );
  modport master (
    output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
`ifdef E203_FLUSH_PC_DIRECT_EN
    output pipe_flush_pc,
`endif
    output halt_req, ifu_req_ready, ifu_rsp_valid,
    input pipe_flush_ack, halt_ack, ifu_req_valid, ifu_req_pc, ifu_rsp_ready, rsp_keep, rsp_pc
  );
endinterface

// File: rtl/e203_ifu_pc_fifo.sv
// e203_ifu_pc_fifo: circular FIFO holding the PCs of outstanding fetch requests
module e203_ifu_pc_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] push_pc,
  input  logic pop,
  output logic [W-1:0] head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr <= pop ? ptr_inc(rd_ptr) : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_pc;
  end
  assign head = mem[rd_ptr];
endmodule

// File: rtl/e203_ifu_flush_rsp.sv
// e203_ifu_flush_rsp: IFU fetch PC owner answering commit flushes and WFI halts.
// Define E203_FLUSH_PC_DIRECT_EN to take the flush PC precomputed instead of via the op1+op2 adder.
module e203_ifu_flush_rsp
  import e203_ifu_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int OUTS_MAX = 2,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input logic clk,
  input logic rst,
  e203_ifu_flush_rsp_if.slave bus
);
  localparam int CW = $clog2(OUTS_MAX+1);
  localparam logic [CW-1:0] MAX_CNT = CW'(OUTS_MAX);
  ifu_state_e state, state_nxt;
  logic [PC_W-1:0] pc_r, pc_nxt, flush_pc, head_pc;
  logic [CW-1:0] outs_cnt, outs_nxt, discard_cnt, discard_nxt;
  logic flush_fire, req_valid, req_fire, rsp_fire;
`ifdef E203_FLUSH_PC_DIRECT_EN
  assign flush_pc = bus.pipe_flush_pc & ~PC_W'(1);
`else
  assign flush_pc = (bus.pipe_flush_add_op1 + bus.pipe_flush_add_op2) & ~PC_W'(1);
`endif
  e203_ifu_pc_fifo #(.DEPTH(OUTS_MAX), .W(PC_W)) u_fifo (
    .clk(clk), .rst(rst), .push(req_fire), .push_pc(pc_r),
    .pop(rsp_fire), .head(head_pc), .count(outs_cnt)
  );
  // A response arriving with nothing outstanding is dropped without popping.
  always_comb begin
    flush_fire  = bus.pipe_flush_req & ~rst;
    req_valid   = ~rst & (state == RUN) & ~bus.halt_req & ~bus.pipe_flush_req & (outs_cnt < MAX_CNT);
    req_fire    = req_valid & bus.ifu_req_ready;
    rsp_fire    = bus.ifu_rsp_valid & ~rst & (outs_cnt != '0);
    outs_nxt    = outs_cnt + CW'(req_fire) - CW'(rsp_fire);
    state_nxt   = (state == RUN) ? ((bus.halt_req && outs_nxt == '0) ? HALT : RUN)
                                 : (bus.halt_req ? HALT : RUN);
    pc_nxt      = flush_fire ? flush_pc : req_fire ? pc_r + PC_W'(PC_INCR) : pc_r;
    discard_nxt = flush_fire ? outs_cnt - CW'(rsp_fire)
                : (rsp_fire && discard_cnt != '0) ? discard_cnt - CW'(1) : discard_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc_r        <= RESET_PC;
      discard_cnt <= '0;
    end else begin
      state       <= state_nxt;
      pc_r        <= pc_nxt;
      discard_cnt <= discard_nxt;
    end
  end
  assign bus.pipe_flush_ack = ~rst;
  assign bus.ifu_rsp_ready  = ~rst;
  assign bus.ifu_req_valid  = req_valid;
  assign bus.ifu_req_pc     = pc_r;
  assign bus.halt_ack       = (state == HALT);
  assign bus.rsp_keep       = rsp_fire & (discard_cnt == '0) & ~flush_fire;
  assign bus.rsp_pc         = head_pc;
endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
// tb_e203_ifu_flush_rsp: directed plus random stimulus checked against an epoch-tagged fetch model
module tb_e203_ifu_flush_rsp;
  localparam int OUTS_MAX = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  e203_ifu_flush_rsp_if #(.PC_W(32)) bif();
  e203_ifu_flush_rsp #(.PC_W(32), .OUTS_MAX(OUTS_MAX), .RESET_PC(32'h0000_1000)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );
  typedef struct { logic [31:0] pc; int ep; } ent_t;
  ent_t q[$];
  logic [31:0] m_pc = 32'h0000_1000;
  int m_ep = 0;
  bit m_halted = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input bit r, input bit fl, input logic [31:0] o1, input logic [31:0] o2,
                      input logic [31:0] fpc, input bit hr, input bit rdy, input bit rv);
    bit exp_valid, fire_rsp;
    ent_t e;
    @(negedge clk);
    rst = r;
    bif.pipe_flush_req = fl;
    bif.pipe_flush_add_op1 = o1;
    bif.pipe_flush_add_op2 = o2;
`ifdef E203_FLUSH_PC_DIRECT_EN
    bif.pipe_flush_pc = fpc;
`endif
    bif.halt_req = hr;
    bif.ifu_req_ready = rdy;
    bif.ifu_rsp_valid = rv;
    #1;
    exp_valid = !r && !m_halted && !hr && !fl && q.size() < OUTS_MAX;
    fire_rsp = !r && rv && q.size() > 0;
    check("req_valid", 32'(bif.ifu_req_valid), 32'(exp_valid));
    check("req_pc", bif.ifu_req_pc, m_pc);
    check("flush_ack", 32'(bif.pipe_flush_ack), 32'(!r));
    check("rsp_ready", 32'(bif.ifu_rsp_ready), 32'(!r));
    check("halt_ack", 32'(bif.halt_ack), 32'(m_halted));
    check("rsp_keep", 32'(bif.rsp_keep), 32'(fire_rsp && q[0].ep == m_ep && !fl));
    if (q.size() > 0) check("rsp_pc", bif.rsp_pc, q[0].pc);
    if (r) begin
      q.delete();
      m_pc = 32'h0000_1000;
      m_halted = 1'b0;
    end else begin
      if (fire_rsp) void'(q.pop_front());
      if (exp_valid && rdy) begin
        e.pc = m_pc;
        e.ep = m_ep;
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
      if (fl) begin
        m_ep++;
`ifdef E203_FLUSH_PC_DIRECT_EN
        m_pc = fpc & ~32'd1;
`else
        m_pc = (o1 + o2) & ~32'd1;
`endif
      end
      if (!m_halted && hr && q.size() == 0) m_halted = 1'b1;
      else if (m_halted && !hr) m_halted = 1'b0;
    end
  endtask
  initial begin
    bit hr;
    bif.pipe_flush_req = 1'b0;
    bif.pipe_flush_add_op1 = '0;
    bif.pipe_flush_add_op2 = '0;
`ifdef E203_FLUSH_PC_DIRECT_EN
    bif.pipe_flush_pc = '0;
`endif
    bif.halt_req = 1'b0;
    bif.ifu_req_ready = 1'b0;
    bif.ifu_rsp_valid = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("first_valid", 32'(bif.ifu_req_valid), 32'd1);
    check("first_pc", bif.ifu_req_pc, 32'h1000);
    check("first_ack", 32'(bif.pipe_flush_ack), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("second_pc", bif.ifu_req_pc, 32'h1004);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("outs_full", 32'(bif.ifu_req_valid), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("stream_rsp0", bif.rsp_pc, 32'h1000);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("stream_rsp1", bif.rsp_pc, 32'h1004);
    check("stream_keep1", 32'(bif.rsp_keep), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("resume_pc", bif.ifu_req_pc, 32'h1008);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 32'h2000, 32'h10, 32'h2010, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("flush_pc", bif.ifu_req_pc, 32'h2010);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("drop0", 32'(bif.rsp_keep), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    check("drop1", 32'(bif.rsp_keep), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("live_keep", 32'(bif.rsp_keep), 32'd1);
    check("live_pc", bif.rsp_pc, 32'h2010);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 32'hFFFF_FFF0, 32'h13, 32'h3001, 0, 0, 1);
    check("coinc_keep", 32'(bif.rsp_keep), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("coinc_drop", 32'(bif.rsp_keep), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
`ifdef E203_FLUSH_PC_DIRECT_EN
    check("direct_pc", bif.ifu_req_pc, 32'h3000);
`else
    check("wrap_pc", bif.ifu_req_pc, 32'h0000_0002);
`endif
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("coinc_live", 32'(bif.rsp_keep), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    check("halt_noissue", 32'(bif.ifu_req_valid), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("halt_ack_set", 32'(bif.halt_ack), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("halt_ack_clr", 32'(bif.halt_ack), 32'd0);
    check("halt_resume", 32'(bif.ifu_req_valid), 32'd1);
    hr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] o1;
      o1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 | $urandom_range(0, 255) : $urandom;
      if ($urandom_range(0, 19) == 0) hr = ~hr;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, o1, $urandom_range(0, 511),
           $urandom, hr, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
